// File: rtl/display_pkg.sv
// Shared types and helpers for the display path: converter state, BCD nibble
// type and the clamp limit used by the binary-to-BCD converter.
package display_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } b2b_state_t;

  typedef logic [3:0] bcd_nibble_t;

  // Largest value representable in both bin_w bits and digits decimal digits.
  function automatic longint unsigned bcd_max(input int bin_w, input int digits);
    longint unsigned bin_lim;
    longint unsigned dec_lim;
    if (bin_w >= 64) bin_lim = '1;
    else             bin_lim = (64'd1 << bin_w) - 64'd1;
    if (digits >= 19) begin
      dec_lim = '1;
    end else begin
      dec_lim = 64'd1;
      for (int i = 0; i < digits; i++) dec_lim = dec_lim * 64'd10;
      dec_lim = dec_lim - 64'd1;
    end
    return (bin_lim < dec_lim) ? bin_lim : dec_lim;
  endfunction

endpackage

// File: rtl/bcd_add3_digit.sv
// Double-dabble correction for one BCD nibble: add 3 when the digit is 5 or
// more, so the following left shift carries correctly into the next digit.
module bcd_add3_digit
  import display_pkg::*;
(
  input  bcd_nibble_t d,
  output bcd_nibble_t q
);

  assign q = (d >= 4'd5) ? d + 4'd3 : d;

endmodule

// File: rtl/bin2bcd_display.sv
// Iterative binary-to-BCD converter (one bit per cycle) with clamping and a
// leading-zero blanking mask for the multiplexed 7-segment driver.
module bin2bcd_display
  import display_pkg::*;
#(
  parameter int BIN_W  = 20,
  parameter int DIGITS = 6
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start_i,
  input  logic [BIN_W-1:0]      bin_i,
  output logic                  ready_o,
  output logic                  done_o,
  output logic [4*DIGITS-1:0]   bcd_o,
  output logic [DIGITS-1:0]     digit_en_o,
  output logic                  ovf_o
);

  localparam int               CNT_W    = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam int               BCD_W    = 4 * DIGITS;
  localparam logic [BIN_W-1:0] MAXV     = BIN_W'(bcd_max(BIN_W, DIGITS));
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

  // Handshake: a request is taken on any edge where ready_o=1 and start_i=1;
  // start_i at any other edge is dropped. done_o pulses for exactly one
  // cycle when bcd_o/digit_en_o/ovf_o have been refreshed.

  b2b_state_t        state_q, state_d;
  logic [BCD_W-1:0]  scratch_q;
  logic [BCD_W-1:0]  scratch_adj;
  logic [BCD_W:0]    shifted;
  logic [BCD_W-1:0]  scratch_d;
  logic [BIN_W-1:0]  shift_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              ovf_q;
  logic [DIGITS-1:0] en_scan;
  logic              accept;
  logic              finish;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3_digit u_add3 (
      .d (scratch_q[4*g +: 4]),
      .q (scratch_adj[4*g +: 4])
    );
  end

  assign shifted   = {scratch_adj, shift_q[BIN_W-1]};
  assign scratch_d = shifted[BCD_W-1:0];

  assign accept = (state_q == IDLE) && start_i;
  assign finish = (state_q == SHIFT) && (state_d == DONE);

  // Blanking scan from the most significant digit down; digit 0 always lit.
  always_comb begin
    en_scan = '0;
    en_scan[DIGITS-1] = |scratch_d[4*(DIGITS-1) +: 4];
    for (int i = DIGITS - 2; i >= 0; i--) begin
      en_scan[i] = en_scan[i+1] | (|scratch_d[4*i +: 4]);
    end
    en_scan[0] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = SHIFT;
      SHIFT:   if (cnt_q == LAST_CNT) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      scratch_q <= '0;
      shift_q   <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
    end else if (accept) begin
      if (bin_i > MAXV) begin
        shift_q <= MAXV;
        ovf_q   <= 1'b1;
      end else begin
        shift_q <= bin_i;
        ovf_q   <= 1'b0;
      end
      scratch_q <= '0;
      cnt_q     <= '0;
    end else if (state_q == SHIFT) begin
      scratch_q <= scratch_d;
      shift_q   <= shift_q << 1;
      cnt_q     <= cnt_q + CNT_W'(1);
    end
  end

  // A carry out of the top digit could only come from an unclamped value,
  // so it is folded into the overflow flag rather than silently dropped.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ready_o    <= 1'b1;
      done_o     <= 1'b0;
      bcd_o      <= '0;
      digit_en_o <= DIGITS'(1);
      ovf_o      <= 1'b0;
    end else begin
      ready_o <= (state_d == IDLE);
      done_o  <= (state_d == DONE);
      if (finish) begin
        bcd_o      <= scratch_d;
        digit_en_o <= en_scan;
        ovf_o      <= ovf_q | shifted[BCD_W];
      end
    end
  end

endmodule

// File: tb/tb_bin2bcd_display.sv
// Directed bench for bin2bcd_display: reset values, conversions, clamping,
// start hold-off while busy and reset during a conversion.
module tb_bin2bcd_display;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start_i;
  logic [19:0] bin_i;
  logic        ready_o;
  logic        done_o;
  logic [23:0] bcd_o;
  logic [5:0]  digit_en_o;
  logic        ovf_o;

  int checks   = 0;
  int failures = 0;
  logic [23:0] exp_q[$];

  bin2bcd_display #(.BIN_W(20), .DIGITS(6)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .start_i    (start_i),
    .bin_i      (bin_i),
    .ready_o    (ready_o),
    .done_o     (done_o),
    .bcd_o      (bcd_o),
    .digit_en_o (digit_en_o),
    .ovf_o      (ovf_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 32'(ready_o), 32'd1);
    check({tag, "_done"},  32'(done_o), 32'd0);
    check({tag, "_bcd"},   32'(bcd_o), 32'd0);
    check({tag, "_en"},    32'(digit_en_o), 32'h01);
    check({tag, "_ovf"},   32'(ovf_o), 32'd0);
  endtask

  // Accept v at edge k, watch 45 cycles; done must appear only after edge k+20.
  task automatic convert(input string tag, input logic [19:0] v, input logic [23:0] exp_bcd,
                         input logic [5:0] exp_en, input logic exp_ovf, input logic poke);
    int n;
    int lat;
    int pulses;
    logic [23:0] got_bcd;
    logic [5:0]  got_en;
    logic        got_ovf;
    logic        ready_after;
    n = 0;
    while (!ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ready_before"}, 32'(ready_o), 32'd1);
    start_i = 1'b1;
    bin_i   = v;
    exp_q.push_back(exp_bcd);
    @(posedge clk);
    lat = -1;
    pulses = 0;
    ready_after = 1'b0;
    got_bcd = 'x;
    got_en = 'x;
    got_ovf = 1'bx;
    for (int c = 0; c < 45; c++) begin
      @(negedge clk);
      if (c == 0) begin
        check({tag, "_ready_busy"}, 32'(ready_o), 32'd0);
        start_i = 1'b0;
        bin_i   = 20'($urandom_range(0, 1048575));
      end
      if (poke && (c == 5 || c == 20)) begin
        start_i = 1'b1;
        bin_i   = 20'd77;
      end
      if (poke && (c == 6 || c == 21)) start_i = 1'b0;
      if (done_o) begin
        pulses++;
        if (lat < 0) begin
          lat = c;
          got_bcd = bcd_o;
          got_en = digit_en_o;
          got_ovf = ovf_o;
        end
      end
      if (c == 21) ready_after = ready_o;
    end
    check({tag, "_latency"}, 32'(lat), 32'd20);
    check({tag, "_pulses"}, 32'(pulses), 32'd1);
    check({tag, "_ready_after"}, 32'(ready_after), 32'd1);
    if (exp_q.size() > 0) begin
      check({tag, "_bcd"}, 32'(got_bcd), 32'(exp_q.pop_front()));
    end else begin
      checks++;
      failures++;
      $error("FAIL %s_bcd observed=empty_queue expected=entry", tag);
    end
    check({tag, "_en"}, 32'(got_en), 32'(exp_en));
    check({tag, "_ovf"}, 32'(got_ovf), 32'(exp_ovf));
  endtask

  initial begin
    int pulses;
    rstn    = 1'b0;
    start_i = 1'b0;
    bin_i   = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rstn = 1'b1;
    @(negedge clk);

    convert("zero",    20'd0,       24'h000000, 6'b000001, 1'b0, 1'b0);
    convert("full",    20'd123456,  24'h123456, 6'b111111, 1'b0, 1'b0);
    convert("inner0",  20'd907,     24'h000907, 6'b000111, 1'b0, 1'b0);
    convert("maxin",   20'd1048575, 24'h999999, 6'b111111, 1'b1, 1'b0);
    convert("after",   20'd5,       24'h000005, 6'b000001, 1'b0, 1'b0);
    convert("limit",   20'd999999,  24'h999999, 6'b111111, 1'b0, 1'b0);
    convert("limit1",  20'd1000000, 24'h999999, 6'b111111, 1'b1, 1'b0);
    convert("holdoff", 20'd42,      24'h000042, 6'b000011, 1'b0, 1'b1);
    convert("hundred", 20'd100,     24'h000100, 6'b000111, 1'b0, 1'b0);

    // Abort a conversion of 999999 ten cycles into SHIFT.
    start_i = 1'b1;
    bin_i   = 20'd999999;
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    repeat (10) @(negedge clk);
    rstn = 1'b0;
    #1;
    check_reset_outputs("abort");
    pulses = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (done_o) pulses++;
    end
    check("abort_no_done", 32'(pulses), 32'd0);
    rstn = 1'b1;
    @(negedge clk);
    convert("post_abort", 20'd1, 24'h000001, 6'b000001, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
